stage_if: RTL and testbench



---
 rtl/stage_if_pkg.sv | 22 ++
 rtl/stage_if_pc_gen.sv | 13 +
 rtl/stage_if.sv | 105 ++++++++++
 tb/tb_stage_if.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// stage_if_pkg: IF->ID interstage layout, fetch FSM states and pack helper
package stage_if_pkg;
  localparam int IF2ID_WIRE_WIDTH = 65;
  localparam int VALID_BIT = 64;
  localparam int NEXT_PC_MSB = 63;
  localparam int NEXT_PC_LSB = 32;
  localparam int INSTR_MSB = 31;
  localparam int INSTR_LSB = 0;
  localparam logic [31:0] IF_NOP_INSTR = 32'h00000000;
  typedef enum logic [1:0] {
    IF_ST_REQ  = 2'd0,
    IF_ST_WAIT = 2'd1,
    IF_ST_HOLD = 2'd2
  } if_state_e;
  function automatic logic [IF2ID_WIRE_WIDTH-1:0] pack_if2id(input logic valid, input logic [31:0] next_pc,
                                                              input logic [31:0] instr);
    pack_if2id = '0;
    pack_if2id[VALID_BIT] = valid;
    pack_if2id[NEXT_PC_MSB:NEXT_PC_LSB] = next_pc;
    pack_if2id[INSTR_MSB:INSTR_LSB] = instr;
  endfunction
endpackage

// File: rtl/stage_if_pc_gen.sv
// stage_if_pc_gen: next fetch address over pc+4, pending redirect and same-cycle branch bypass
module stage_if_pc_gen (
  input  logic [31:0] pc_i,
  input  logic        redir_pending_i,
  input  logic [31:0] redir_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] next_fetch_o
);
  assign next_fetch_o = redir_pending_i ? redir_target_i :
                        branch_taken_i  ? (branch_target_i & 32'hFFFF_FFFC) :
                                          pc_i + 32'd4;
endmodule

// File: rtl/stage_if.sv
// stage_if: MIPS instruction fetch stage; req/ack imem fetch, stall hold buffer,
// delay-slot branch redirect into the IF->ID register
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [31:0]                 branch_target,
  output logic                        imem_req,
  output logic [31:0]                 imem_addr,
  input  logic                        imem_ack,
  input  logic [31:0]                 imem_data,
  output logic [IF2ID_WIRE_WIDTH-1:0] interstage_if2id
);
  if_state_e                 state_q, state_d;
  logic [31:0]               pc_q, pc_d, addr_q, addr_d, hold_instr_q, hold_instr_d;
  logic [31:0]               redir_target_q, redir_target_d, next_fetch, deliver_instr;
  logic                      req_q, req_d, hold_valid_q, hold_valid_d, redir_pending_q, redir_pending_d;
  logic                      deliver;
  logic [IF2ID_WIRE_WIDTH-1:0] out_q, out_d;

  stage_if_pc_gen u_pc_gen (
    .pc_i           (pc_q),
    .redir_pending_i(redir_pending_q),
    .redir_target_i (redir_target_q),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .next_fetch_o   (next_fetch)
  );

  assign deliver = !stall && ((state_q == IF_ST_WAIT && imem_ack) || (state_q == IF_ST_HOLD && hold_valid_q));
  assign deliver_instr = state_q == IF_ST_HOLD ? hold_instr_q : imem_data;

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    req_d = req_q;
    hold_instr_d = hold_instr_q;
    hold_valid_d = hold_valid_q;
    redir_pending_d = redir_pending_q;
    redir_target_d = redir_target_q;
    out_d = stall   ? out_q :
            deliver ? pack_if2id(1'b1, pc_q + 32'd4, deliver_instr) :
                      pack_if2id(1'b0, out_q[NEXT_PC_MSB:NEXT_PC_LSB], NOP_INSTR);
    // a branch seen during a delivery is bypassed straight into pc by pc_gen
    if (branch_taken && !redir_pending_q && !deliver) begin
      redir_pending_d = 1'b1;
      redir_target_d = branch_target & 32'hFFFF_FFFC;
    end
    case (state_q)
      IF_ST_REQ: begin
        addr_d = pc_q;
        req_d = 1'b1;
        state_d = IF_ST_WAIT;
      end
      IF_ST_WAIT: if (imem_ack) begin
        req_d = 1'b0;
        state_d = stall ? IF_ST_HOLD : IF_ST_REQ;
        hold_instr_d = stall ? imem_data : hold_instr_q;
        hold_valid_d = stall;
      end
      IF_ST_HOLD: state_d = stall ? IF_ST_HOLD : IF_ST_REQ;
      default: state_d = IF_ST_REQ;
    endcase
    if (deliver) begin
      pc_d = next_fetch;
      redir_pending_d = 1'b0;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IF_ST_REQ;
      pc_q <= RESET_PC;
      addr_q <= '0;
      req_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_valid_q <= 1'b0;
      redir_pending_q <= 1'b0;
      redir_target_q <= '0;
      out_q <= pack_if2id(1'b0, 32'd0, NOP_INSTR);
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      req_q <= req_d;
      hold_instr_q <= hold_instr_d;
      hold_valid_q <= hold_valid_d;
      redir_pending_q <= redir_pending_d;
      redir_target_q <= redir_target_d;
      out_q <= out_d;
    end
  end

  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign interstage_if2id = out_q;
endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed fetch/stall/branch/reset sequence with hand-computed IF->ID values
module tb_stage_if;
  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_ack, imem_req;
  logic [31:0] branch_target, imem_addr, imem_data;
  logic [64:0] if2id;
  int          checks = 0;
  int          errors = 0;

  stage_if dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_data       (imem_data),
    .interstage_if2id(if2id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // entered in the first WAIT cycle; lat = WAIT cycles including the ack cycle
  task automatic fetch(input int lat, input logic [31:0] addr, input logic [31:0] data, input logic [31:0] npc);
    for (int i = 0; i < lat; i++) begin
      chk("wait_req", {64'd0, imem_req}, 65'd1);
      chk("wait_addr", {33'd0, imem_addr}, {33'd0, addr});
      chk("wait_bubble", {if2id[64], if2id[31:0]}, 65'd0);
      if (i == lat - 1) begin
        imem_ack = 1'b1;
        imem_data = data;
      end
      tick();
    end
    imem_ack = 1'b0;
    imem_data = '0;
    chk("deliver", if2id, {1'b1, npc, data});
    chk("deliver_req_drop", {64'd0, imem_req}, 65'd0);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    imem_ack = 1'b0;
    imem_data = '0;
    tick();
    tick();
    chk("rst_req", {64'd0, imem_req}, 65'd0);
    chk("rst_addr", {33'd0, imem_addr}, 65'd0);
    chk("rst_out", if2id, 65'd0);
    rst = 1'b1;
    tick();
    fetch(2, 32'hBFC00000, 32'h11111111, 32'hBFC00004);
    fetch(2, 32'hBFC00004, 32'h22222222, 32'hBFC00008);
    chk("br_addr", {33'd0, imem_addr}, {33'd0, 32'hBFC00008});
    branch_taken = 1'b1;
    branch_target = 32'h80000101;
    tick();
    branch_taken = 1'b0;
    branch_target = '0;
    chk("br_addr_stable", {33'd0, imem_addr}, {33'd0, 32'hBFC00008});
    imem_ack = 1'b1;
    imem_data = 32'h33333333;
    tick();
    imem_ack = 1'b0;
    chk("delay_slot", if2id, {1'b1, 32'hBFC0000C, 32'h33333333});
    tick();
    chk("br_target_addr", {33'd0, imem_addr}, {33'd0, 32'h80000100});
    fetch(2, 32'h80000100, 32'h44444444, 32'h80000104);
    fetch(5, 32'h80000104, 32'h55555555, 32'h80000108);
    stall = 1'b1;
    tick();
    chk("stall_frozen", if2id, {1'b0, 32'h80000108, 32'h0});
    imem_ack = 1'b1;
    imem_data = 32'h66666666;
    tick();
    imem_ack = 1'b0;
    imem_data = '0;
    chk("stall_ack_out", if2id, {1'b0, 32'h80000108, 32'h0});
    chk("stall_ack_req", {64'd0, imem_req}, 65'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_out", if2id, {1'b0, 32'h80000108, 32'h0});
      chk("hold_req", {64'd0, imem_req}, 65'd0);
    end
    stall = 1'b0;
    tick();
    chk("hold_release", if2id, {1'b1, 32'h8000010C, 32'h66666666});
    tick();
    chk("after_hold_out", if2id, {1'b0, 32'h8000010C, 32'h0});
    chk("after_hold_addr", {33'd0, imem_addr}, {33'd0, 32'h8000010C});
    imem_ack = 1'b1;
    imem_data = 32'h77777777;
    branch_taken = 1'b1;
    branch_target = 32'hFFFFFFFE;
    tick();
    imem_ack = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    chk("bypass_slot", if2id, {1'b1, 32'h80000110, 32'h77777777});
    tick();
    chk("bypass_addr", {33'd0, imem_addr}, {33'd0, 32'hFFFFFFFC});
    fetch(2, 32'hFFFFFFFC, 32'h88888888, 32'h00000000);
    chk("wrap_addr", {33'd0, imem_addr}, 65'd0);
    branch_taken = 1'b1;
    branch_target = 32'h12340000;
    tick();
    branch_target = 32'h55550000;
    tick();
    branch_taken = 1'b0;
    branch_target = '0;
    imem_ack = 1'b1;
    imem_data = 32'h99999999;
    tick();
    imem_ack = 1'b0;
    chk("pending_slot", if2id, {1'b1, 32'h00000004, 32'h99999999});
    tick();
    chk("second_br_ignored", {33'd0, imem_addr}, {33'd0, 32'h12340000});
    chk("mid_fetch_req", {64'd0, imem_req}, 65'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_req", {64'd0, imem_req}, 65'd0);
    chk("midrst_addr", {33'd0, imem_addr}, 65'd0);
    chk("midrst_out", if2id, 65'd0);
    imem_ack = 1'b1;
    imem_data = 32'hDEADBEEF;
    tick();
    imem_ack = 1'b0;
    imem_data = '0;
    chk("late_ack_out", if2id, 65'd0);
    fetch(2, 32'hBFC00000, 32'hAAAAAAAA, 32'hBFC00004);
    chk("restart_next_addr", {33'd0, imem_addr}, {33'd0, 32'hBFC00004});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
